// File: rtl/i2s_rx_dma_ctrl.sv
// rtl/i2s_rx_dma_ctrl.sv - I2S RX FIFO drain/burst scheduler onto a valid/ready stream
// Optional 16-bit sample packing under `I2S_RX_DMA_PACK16_EN.
module i2s_rx_dma_ctrl #(
    parameter int TO_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [4:0]       burst_len,
    input  logic [TO_W-1:0]  timeout,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic [4:0]       fifo_level,
    input  logic [31:0]      fifo_rdata,
`ifdef I2S_RX_DMA_PACK16_EN
    input  logic             pack16,
`endif
    output logic             fifo_rd,
    output logic             m_valid,
    output logic [31:0]      m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic             flush_pulse,
    output logic [CNT_W-1:0] burst_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    localparam logic [TO_W-1:0]  TO_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t          state;
    logic [5:0]      beats_left;
    logic [TO_W-1:0] to_cnt;

    logic [5:0]  eff_level;
    logic [4:0]  target;
    logic        out_free;
    logic        out_hs;
    logic        go_full;
    logic        go_flush;
    logic        in_burst;
    logic        load;
    logic [31:0] load_data;
    logic [5:0]  full_words;
    logic [5:0]  flush_words;

    // A full FIFO reports level 0, so occupancy needs the extra bit.
    assign eff_level = fifo_full ? 6'd32 : {1'b0, fifo_level};
    assign target    = (burst_len == 5'd0) ? 5'd1 : burst_len;
    assign out_free  = !m_valid || m_ready;
    assign out_hs    = m_valid && m_ready;
    assign in_burst  = (state == S_BURST) && (beats_left != 6'd0) && !fifo_empty;
    assign busy      = (state != S_IDLE);
    assign full_words = {1'b0, target};

`ifdef I2S_RX_DMA_PACK16_EN
    logic        have_lo;
    logic [15:0] lo_q;
    logic [5:0]  samp_left;
    logic        pop_lo;
    logic        pop_hi;
    logic        thresh_hit;

    // Packed mode: first sample parks in lo_q, second sample (or a lone odd one) loads the output.
    assign pop_lo      = pack16 && in_burst && !have_lo && (samp_left >= 6'd2);
    assign pop_hi      = pack16 && in_burst && out_free && (have_lo || samp_left == 6'd1);
    assign load        = pack16 ? pop_hi : (in_burst && out_free);
    assign fifo_rd     = pack16 ? (pop_lo || pop_hi) : load;
    assign load_data   = !pack16 ? fifo_rdata :
                         have_lo ? {fifo_rdata[15:0], lo_q} : {16'h0000, fifo_rdata[15:0]};
    assign thresh_hit  = pack16 ? (eff_level >= {target, 1'b0}) : (eff_level >= {1'b0, target});
    assign flush_words = pack16 ? ((eff_level + 6'd1) >> 1) : eff_level;
`else
    logic thresh_hit;

    assign load        = in_burst && out_free;
    assign fifo_rd     = load;
    assign load_data   = fifo_rdata;
    assign thresh_hit  = (eff_level >= {1'b0, target});
    assign flush_words = eff_level;
`endif

    assign go_full  = (state == S_WAIT) && en && thresh_hit;
    assign go_flush = (state == S_WAIT) && en && !thresh_hit && (timeout != '0) &&
                      !fifo_empty && (to_cnt == timeout - TO_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            beats_left  <= 6'd0;
            to_cnt      <= '0;
            m_valid     <= 1'b0;
            m_data      <= 32'h0;
            m_last      <= 1'b0;
            flush_pulse <= 1'b0;
            burst_count <= '0;
        end else begin
            flush_pulse <= 1'b0;

            // A pop reloads the output register even when the old beat is handshaking.
            if (load) begin
                m_data     <= load_data;
                m_valid    <= 1'b1;
                m_last     <= (beats_left == 6'd1);
                beats_left <= beats_left - 6'd1;
            end else if (out_hs) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (en) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!en) begin
                        state  <= S_IDLE;
                        to_cnt <= '0;
                    end else if (go_full) begin
                        state      <= S_BURST;
                        beats_left <= full_words;
                        to_cnt     <= '0;
                    end else if (go_flush) begin
                        state       <= S_BURST;
                        beats_left  <= flush_words;
                        flush_pulse <= 1'b1;
                        to_cnt      <= '0;
                    end else if (fifo_empty) begin
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end
                S_BURST: begin
                    if (out_hs && m_last) begin
                        burst_count <= burst_count + CNT_ONE;
                        state       <= en ? S_WAIT : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef I2S_RX_DMA_PACK16_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_lo   <= 1'b0;
            lo_q      <= 16'h0;
            samp_left <= 6'd0;
        end else if (go_full || go_flush) begin
            have_lo   <= 1'b0;
            samp_left <= go_full ? {target, 1'b0} : eff_level;
        end else if (pop_lo) begin
            have_lo   <= 1'b1;
            lo_q      <= fifo_rdata[15:0];
            samp_left <= samp_left - 6'd1;
        end else if (pop_hi) begin
            have_lo   <= 1'b0;
            samp_left <= samp_left - 6'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_rx_dma_ctrl.sv
// tb/tb_i2s_rx_dma_ctrl.sv - scoreboard bench for i2s_rx_dma_ctrl with a show-ahead FIFO model
module tb_i2s_rx_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [4:0]  burst_len = 5'd0;
    logic [15:0] timeout = 16'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_full = 1'b0;
    logic [4:0]  fifo_level = 5'd0;
    logic [31:0] fifo_rdata = 32'h0;
    logic        fifo_rd;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        flush_pulse;
    logic [15:0] burst_count;

    i2s_rx_dma_ctrl #(.TO_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .burst_len(burst_len), .timeout(timeout),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
        .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd), .m_valid(m_valid), .m_data(m_data),
        .m_last(m_last), .m_ready(m_ready), .busy(busy), .flush_pulse(flush_pulse),
        .burst_count(burst_count)
    );

    always #5 clk = ~clk;

    logic [31:0] fq[$];
    logic [31:0] pend[$];
    logic [32:0] expq[$];
    int n_checks = 0;
    int n_pass = 0;
    int hs_count = 0;
    int bursts_model = 0;
    int flush_cnt = 0;
    bit flush_ok = 0;
    int rdy_pct = 100;
    bit rd_q = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    endtask

    // Show-ahead 32-deep FIFO; producer words queue in pend and enter one per cycle.
    always begin
        int sz;
        @(negedge clk);
        rd_q = fifo_rd;
        @(posedge clk);
        if (!rst_n) begin
            fq.delete();
        end else begin
            if (rd_q) begin
                if (fq.size() == 0) chk("pop_while_empty", fifo_empty, 0);
                else void'(fq.pop_front());
            end
            if (pend.size() > 0 && fq.size() < 32) fq.push_back(pend.pop_front());
        end
        #1;
        sz = fq.size();
        fifo_empty = (sz == 0);
        fifo_full  = (sz == 32);
        fifo_level = sz[4:0];
        fifo_rdata = (sz != 0) ? fq[0] : 32'h0;
    end

    always begin
        @(posedge clk);
        #1;
        m_ready = ($urandom_range(99) < rdy_pct);
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability and burst counts.
    logic [31:0] held_d;
    logic        held_l;
    bit held = 0;
    bit cnt_pend = 0;
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            held = 0;
            cnt_pend = 0;
        end else begin
            if (cnt_pend) begin
                chk("burst_count", burst_count, bursts_model);
                cnt_pend = 0;
            end
            if (flush_pulse) begin
                flush_cnt++;
                if (!flush_ok) chk("unexpected_flush", flush_pulse, 0);
            end
            if (fifo_rd && !busy) chk("rd_outside_burst", fifo_rd, 0);
            if (held) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, held_d);
                chk("stall_last", m_last, held_l);
            end
            held   = m_valid && !m_ready;
            held_d = m_data;
            held_l = m_last;
            if (m_valid && m_ready) begin
                hs_count++;
                if (expq.size() == 0) begin
                    chk("unexpected_beat", expq.size(), 1);
                end else begin
                    e = expq.pop_front();
                    chk("beat", {m_last, m_data}, e);
                    if (e[32]) begin
                        bursts_model++;
                        cnt_pend = 1;
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] d, input bit last);
        pend.push_back(d);
        expq.push_back({last, d});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((expq.size() != 0 || pend.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", expq.size(), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic wait_hs(input int target_cnt, input int budget);
        int n = 0;
        while (hs_count < target_cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("hs_reached", (hs_count >= target_cnt) ? 1 : 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        int tgt;
        int nb;

        #12;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_flush", flush_pulse, 0);
        chk("rst_burst_count", burst_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_rd", fifo_rd, 0);

        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        burst_len = 5'd4;
        rdy_pct = 100;

        // Normal four-word burst.
        for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + i, i == 3);
        drain(200);
        chk("normal_fifo_empty", fq.size(), 0);
        chk("normal_count", burst_count, 1);

        // Backpressure held for five cycles mid-burst.
        @(negedge clk);
        burst_len = 5'd3;
        base = hs_count;
        for (int i = 0; i < 3; i++) push_word(32'hB000_0000 + i, i == 2);
        wait_hs(base + 1, 200);
        rdy_pct = 0;
        repeat (5) @(posedge clk);
        rdy_pct = 100;
        drain(200);

        // Timeout flush of a partial burst.
        @(negedge clk);
        burst_len = 5'd8;
        timeout = 16'd10;
        flush_ok = 1;
        flush_cnt = 0;
        for (int i = 0; i < 3; i++) push_word(32'hC000_0000 + i, i == 2);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (fifo_empty && n < 20);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!flush_pulse && n < 40);
        chk("flush_delay", n, 10);
        drain(200);
        chk("flush_count", flush_cnt, 1);
        timeout = 16'd0;
        flush_ok = 0;

        // Random full-size bursts under random backpressure.
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            burst_len = (s == 0) ? 5'd0 : 5'($urandom_range(1, 8));
            tgt = (burst_len == 5'd0) ? 1 : int'(burst_len);
            nb = $urandom_range(1, 3);
            rdy_pct = $urandom_range(30, 100);
            for (int w = 0; w < tgt * nb; w++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push_word($urandom, (w % tgt) == tgt - 1);
            end
            drain(3000);
        end

        // Full FIFO with burst_len 31.
        @(negedge clk);
        rdy_pct = 100;
        en = 1'b0;
        burst_len = 5'd31;
        for (int i = 0; i < 32; i++) push_word(32'hF000_0000 + i, i >= 30);
        n = 0;
        while (fq.size() < 32 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        en = 1'b1;
        n = 0;
        while (expq.size() > 1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        chk("full_remaining", fq.size(), 1);
        chk("full_no_valid", m_valid, 0);
        chk("full_busy_wait", busy, 1);
        burst_len = 5'd1;
        drain(200);

        // en dropped after beat 2 of 5.
        @(negedge clk);
        burst_len = 5'd5;
        base = hs_count;
        for (int i = 0; i < 5; i++) push_word(32'hD000_0000 + i, i == 4);
        wait_hs(base + 2, 300);
        en = 1'b0;
        drain(300);
        chk("en_drop_busy", busy, 0);

        // Asynchronous reset while beat 2 is presented.
        @(negedge clk);
        en = 1'b1;
        burst_len = 5'd4;
        base = hs_count;
        for (int i = 0; i < 4; i++) push_word(32'hE000_0000 + i, i == 3);
        wait_hs(base + 1, 200);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_last", m_last, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_count", burst_count, 0);
        expq.delete();
        pend.delete();
        bursts_model = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        burst_len = 5'd2;
        push_word(32'h1234_0001, 1'b0);
        push_word(32'h1234_0002, 1'b1);
        drain(200);
        chk("post_reset_count", burst_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
